rxd_packetizer: RTL and testbench
=================================

# rxd_packetizer

Collects 32-bit words from a debug-data source stream, frames them into length-prefixed packets, and drives the receive-stream (`axi_str_rxd_*`) side of the AXI-Stream FIFO so software reads whole packets with a header and `tlast`. It sits directly upstream of the stream FIFO's RX port. It buffers up to `MAX_WORDS` words, then emits one header word followed by the buffered payload.

## Interface
- `MAX_WORDS`, 16: payload buffer depth in words; power of 2, 2..256.
- `TIMEOUT`, 1024: idle cycles before a partial packet is flushed; 1..65535. Used only with the timeout macro.
- `s_axi_aclk` in 1: single clock.
- `s_axi_aresetn` in 1: reset, asynchronous, active-low.
- `in_tdata` in 32: source word.
- `in_tvalid` in 1: source valid.
- `in_tready` out 1: block accepts a word.
- `in_tlast` in 1: source forces a flush after this word.
- `axi_str_rxd_tdata` out 32: framed word to the FIFO.
- `axi_str_rxd_tvalid` out 1: framed word valid.
- `axi_str_rxd_tready` in 1: FIFO accepts.
- `axi_str_rxd_tlast` out 1: last payload word of the packet.
- `busy` out 1: high in HDR or DRAIN state.

## Operation
- States:
  - FILL (reset state).
  - HDR: emit header.
  - DRAIN: emit payload.
- Counters:
  - `count`: words buffered, width clog2(MAX_WORDS)+1.
  - `rd`: drain index.
  - `seq`: 8-bit packet sequence, resets to 0.
- FILL:
  - `in_tready`=1. A word is accepted on `in_tvalid & in_tready` and written to `buf[count]`, then `count++`.
  - Go to HDR after the accept when `count+1==MAX_WORDS` or `in_tlast`=1.
- HDR:
  - `axi_str_rxd_tdata`={8'hA5, seq, 16'(count)}, `tvalid`=1, `tlast`=0. `count` is always ≥1 here.
  - On handshake: `rd`=0, go to DRAIN.
- DRAIN:
  - `tdata`=`buf[rd]`, `tvalid`=1, `tlast`=(`rd==count-1`).
  - On each handshake `rd++`.
  - On the handshake of the last word: `count`=0, `seq++` (wraps 255→0), go to FILL.
- `in_tready`=0 in HDR and DRAIN; no source data is lost or overwritten.
- The FILL state with `count`=0 and no input stays idle indefinitely. No empty packets are ever emitted.
- `in_tlast` on a word that also fills the buffer produces exactly one flush.

## Timing
- Reset values (asserted asynchronously):
  - `in_tready`=0, `axi_str_rxd_tvalid`=0, `axi_str_rxd_tlast`=0, `axi_str_rxd_tdata`=0, `busy`=0.
  - State FILL, `count`=0, `seq`=0.
- `in_tready` is registered. It rises on the first clock edge after reset deassertion.
- Throughput:
  - In FILL, one word is accepted per cycle.
  - In DRAIN, one word is emitted per cycle while `axi_str_rxd_tready`=1.
- Latency: the word that triggers a flush is accepted at edge N; the header is valid after edge N+1.
- Output handshake:
  - Once `tvalid` is high, `tdata` and `tlast` stay stable until the handshake.
  - `tvalid` never drops without a handshake.
- All outputs are driven from registers. There is no combinational path from `in_*` or `axi_str_rxd_tready` to any output.
- A packet of k payload words takes exactly k+1 output handshakes.
- Reset asserted mid-packet discards the buffer, the partial packet and `seq`. `tvalid` drops immediately.

## Configuration
- `RXD_PKT_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in FILL while `count`>0 and no word is accepted. It clears on every accept.
  - When the counter reaches `TIMEOUT`, go to HDR on the next edge. A partial packet is flushed at exactly `TIMEOUT` idle cycles after the last accept.
  - A `count`=0 buffer never times out.
- `RXD_PKT_TIMEOUT_EN` undefined:
  - No counter; the `TIMEOUT` parameter is ignored.
  - Flush only on buffer full or `in_tlast`. A partial packet waits indefinitely.

## Test plan
- **Full flush**: MAX_WORDS=16; feed 16 words 0x100..0x10F with `axi_str_rxd_tready`=1 → output 0xA500_0010, then 0x100..0x10F, `tlast` only on 0x10F; then `in_tready` returns to 1.
- **tlast flush**: 3 words 0xA, 0xB, 0xC with `in_tlast` on 0xC → header 0xA500_0003, then 0xA, 0xB, 0xC (`tlast` on 0xC); a second packet carries header `seq`=0x01.
- **Backpressure**: randomly toggle `axi_str_rxd_tready` during DRAIN → `tdata`/`tlast` stable while stalled; payload order and count exact; `in_tready`=0 throughout.
- **Timeout (macro on)**: TIMEOUT=8; feed 2 words, then idle → header 0xA5xx_0002 valid exactly 9 edges after the last accept. With the macro off → no output after 1000 idle cycles.
- **Seq wrap**: send 257 single-word packets → headers carry `seq` 0x00..0xFF, then 0x00.
- **Reset mid-DRAIN**: assert `s_axi_aresetn` low during the second payload word → `tvalid`=0 immediately; after release, the first packet header has `seq`=0 and contains no stale words.

Source files
------------

// File: rtl/rxd_packetizer.sv
// rtl/rxd_packetizer.sv - frames debug words into header+payload packets for the stream FIFO RX port (optional idle flush: RXD_PKT_TIMEOUT_EN)
module rxd_packetizer #(
    parameter int MAX_WORDS = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    output logic [31:0] axi_str_rxd_tdata,
    output logic        axi_str_rxd_tvalid,
    input  logic        axi_str_rxd_tready,
    output logic        axi_str_rxd_tlast,
    output logic        busy
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_WORDS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Reject out-of-range configurations at elaboration time.
    if (MAX_WORDS < 2 || MAX_WORDS > 256 || (1 << AW) != MAX_WORDS ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("rxd_packetizer: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HDR,
        ST_DRAIN
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [AW-1:0]   rd, rd_nx;
    logic [7:0]      seq, seq_nx;
    logic            tready_nx;
    logic            tvalid_nx;
    logic            tlast_nx;
    logic [31:0]     tdata_nx;
    logic [31:0]     mem [MAX_WORDS];

    logic            accept;
    logic            out_hs;
    logic [CW-1:0]   count_inc;
    logic [AW-1:0]   rd_inc;

`ifdef RXD_PKT_TIMEOUT_EN
    logic [15:0]     idle, idle_nx;
`endif

    assign accept    = (state == ST_FILL) && in_tvalid && in_tready;
    assign out_hs    = axi_str_rxd_tvalid && axi_str_rxd_tready;
    assign count_inc = count + ONE;
    assign rd_inc    = rd + 1'b1;

    // Payload buffer write; contents need no reset since count gates every read.
    always_ff @(posedge s_axi_aclk) begin
        if (accept) begin
            mem[count[AW-1:0]] <= in_tdata;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state              <= ST_FILL;
            count              <= '0;
            rd                 <= '0;
            seq                <= '0;
            in_tready          <= 1'b0;
            axi_str_rxd_tvalid <= 1'b0;
            axi_str_rxd_tlast  <= 1'b0;
            axi_str_rxd_tdata  <= '0;
            busy               <= 1'b0;
`ifdef RXD_PKT_TIMEOUT_EN
            idle               <= '0;
`endif
        end else begin
            state              <= state_nx;
            count              <= count_nx;
            rd                 <= rd_nx;
            seq                <= seq_nx;
            in_tready          <= tready_nx;
            axi_str_rxd_tvalid <= tvalid_nx;
            axi_str_rxd_tlast  <= tlast_nx;
            axi_str_rxd_tdata  <= tdata_nx;
            busy               <= (state_nx != ST_FILL);
`ifdef RXD_PKT_TIMEOUT_EN
            idle               <= idle_nx;
`endif
        end
    end

    // Next-state logic and next values of every output register.
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        rd_nx     = rd;
        seq_nx    = seq;
        tready_nx = in_tready;
        tvalid_nx = axi_str_rxd_tvalid;
        tlast_nx  = axi_str_rxd_tlast;
        tdata_nx  = axi_str_rxd_tdata;
`ifdef RXD_PKT_TIMEOUT_EN
        idle_nx   = idle;
`endif
        unique case (state)
            ST_FILL: begin
                tready_nx = 1'b1;
                if (accept) begin
                    count_nx = count_inc;
                    if (count_inc == FULL || in_tlast) begin
                        state_nx  = ST_HDR;
                        tready_nx = 1'b0;
                    end
                end
`ifdef RXD_PKT_TIMEOUT_EN
                // Idle cycles are counted only while something is buffered;
                // leaving on the cycle the count would hit TIMEOUT puts the
                // header on the bus TIMEOUT+1 edges after the last accept.
                if (accept) begin
                    idle_nx = '0;
                end else if (count != '0) begin
                    if (idle + 16'd1 == 16'(TIMEOUT)) begin
                        idle_nx   = '0;
                        state_nx  = ST_HDR;
                        tready_nx = 1'b0;
                    end else begin
                        idle_nx = idle + 16'd1;
                    end
                end
`endif
            end
            ST_HDR: begin
                // Header is loaded one cycle after entry, then held until taken.
                if (!axi_str_rxd_tvalid) begin
                    tvalid_nx = 1'b1;
                    tlast_nx  = 1'b0;
                    tdata_nx  = {8'hA5, seq, 16'(count)};
                end else if (out_hs) begin
                    state_nx = ST_DRAIN;
                    rd_nx    = '0;
                    tdata_nx = mem[0];
                    tlast_nx = (count == ONE);
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    if (axi_str_rxd_tlast) begin
                        state_nx  = ST_FILL;
                        count_nx  = '0;
                        seq_nx    = seq + 8'd1;
                        tvalid_nx = 1'b0;
                        tlast_nx  = 1'b0;
                        tready_nx = 1'b1;
                    end else begin
                        rd_nx    = rd_inc;
                        tdata_nx = mem[rd_inc];
                        tlast_nx = (CW'(rd_inc) == count - ONE);
                    end
                end
            end
            default: begin
                state_nx = ST_FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_rxd_packetizer.sv
// tb/tb_rxd_packetizer.sv - directed self-checking bench for rxd_packetizer
module tb_rxd_packetizer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        rx_tlast;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int exp_seq = 0;

    rxd_packetizer #(.MAX_WORDS(16), .TIMEOUT(8)) dut (
        .s_axi_aclk         (clk),
        .s_axi_aresetn      (rst_n),
        .in_tdata           (in_tdata),
        .in_tvalid          (in_tvalid),
        .in_tready          (in_tready),
        .in_tlast           (in_tlast),
        .axi_str_rxd_tdata  (rx_tdata),
        .axi_str_rxd_tvalid (rx_tvalid),
        .axi_str_rxd_tready (rx_tready),
        .axi_str_rxd_tlast  (rx_tlast),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer n words base, base+1, ... back to back; optional in_tlast on the final one.
    task automatic feed(input int n, input logic [31:0] base, input logic last);
        for (int i = 0; i < n; i++) begin
            int w;
            in_tdata  = base + 32'(i);
            in_tlast  = last && (i == n - 1);
            in_tvalid = 1'b1;
            w = 0;
            while (!in_tready && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("feed_ready", {31'd0, in_tready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic recv_word(input string tag, input logic [31:0] data, input logic last);
        int w;
        rx_tready = 1'b1;
        w = 0;
        while (!rx_tvalid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, {31'd0, rx_tvalid}, 32'd1);
        chk({tag, "_data"}, rx_tdata, data);
        chk({tag, "_last"}, {31'd0, rx_tlast}, {31'd0, last});
        @(negedge clk);
    endtask

    task automatic recv_pkt(input string tag, input int n, input logic [31:0] base);
        logic [31:0] hdr;
        hdr = {8'hA5, 8'(exp_seq), 16'(n)};
        recv_word({tag, "_hdr"}, hdr, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_word({tag, "_pay"}, base + 32'(i), i == n - 1);
        end
        exp_seq = (exp_seq + 1) % 256;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_seq = 0;
    endtask

    initial begin
        logic [31:0] prev_data;
        logic        prev_last;
        logic        stalled;
        int          idx;
        int          cyc;

        rst_n     = 1'b0;
        in_tdata  = '0;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        rx_tready = 1'b1;

        // Reset values
        #2;
        chk("rst_in_tready", {31'd0, in_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, rx_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, rx_tlast}, 32'd0);
        chk("rst_tdata", rx_tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_tready_low", {31'd0, in_tready}, 32'd0);
        @(negedge clk);
        chk("rel_in_tready_high", {31'd0, in_tready}, 32'd1);

        // Full flush: 16 words, header one edge after the filling accept
        feed(16, 32'h100, 1'b0);
        chk("full_tvalid_lat0", {31'd0, rx_tvalid}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_in_tready", {31'd0, in_tready}, 32'd0);
        @(negedge clk);
        chk("full_tvalid_lat1", {31'd0, rx_tvalid}, 32'd1);
        recv_pkt("full", 16, 32'h100);
        chk("full_ready_back", {31'd0, in_tready}, 32'd1);
        chk("full_busy_done", {31'd0, busy}, 32'd0);
        chk("full_tvalid_done", {31'd0, rx_tvalid}, 32'd0);

        // tlast flush, then a second packet with the next sequence number
        feed(3, 32'hA, 1'b1);
        chk("tl_tvalid_lat0", {31'd0, rx_tvalid}, 32'd0);
        @(negedge clk);
        chk("tl_hdr", rx_tdata, 32'hA501_0003);
        recv_pkt("tl1", 3, 32'hA);
        feed(2, 32'hB0, 1'b1);
        recv_pkt("tl2", 2, 32'hB0);

        // Empty buffer stays idle
        repeat (30) @(negedge clk);
        chk("idle_tvalid", {31'd0, rx_tvalid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure during HDR/DRAIN with random tready
        feed(5, 32'h200, 1'b1);
        idx = 0;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (cyc = 0; cyc < 300 && idx < 6; cyc++) begin
            chk("bp_in_tready", {31'd0, in_tready}, 32'd0);
            if (rx_tvalid) begin
                if (stalled) begin
                    chk("bp_stable_data", rx_tdata, prev_data);
                    chk("bp_stable_last", {31'd0, rx_tlast}, {31'd0, prev_last});
                end
                if (idx == 0) begin
                    chk("bp_hdr", rx_tdata, {8'hA5, 8'(exp_seq), 16'd5});
                end else begin
                    chk("bp_pay", rx_tdata, 32'h200 + 32'(idx - 1));
                end
                chk("bp_last", {31'd0, rx_tlast}, {31'd0, idx == 5});
                prev_data = rx_tdata;
                prev_last = rx_tlast;
                rx_tready = 1'($urandom_range(1, 0));
                stalled   = !rx_tready;
                if (rx_tready) idx++;
            end else begin
                chk("bp_valid_drop", {31'd0, stalled}, 32'd0);
                rx_tready = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
        end
        chk("bp_count", idx, 32'd6);
        rx_tready = 1'b1;
        exp_seq = (exp_seq + 1) % 256;

`ifdef RXD_PKT_TIMEOUT_EN
        // Timeout flush: header valid 9 edges after the last accept
        feed(2, 32'h50, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_wait", {31'd0, rx_tvalid}, 32'd0);
        end
        @(negedge clk);
        chk("to_hdr_valid", {31'd0, rx_tvalid}, 32'd1);
        chk("to_hdr", rx_tdata, {8'hA5, 8'(exp_seq), 16'd2});
        recv_pkt("to", 2, 32'h50);
`else
        // No timeout: a partial packet waits, then tlast flushes it
        feed(2, 32'h50, 1'b0);
        repeat (1000) @(negedge clk);
        chk("nto_tvalid", {31'd0, rx_tvalid}, 32'd0);
        chk("nto_busy", {31'd0, busy}, 32'd0);
        chk("nto_in_tready", {31'd0, in_tready}, 32'd1);
        feed(1, 32'h52, 1'b1);
        recv_pkt("nto", 3, 32'h50);
`endif

        // Sequence wrap over 257 single-word packets
        do_reset();
        for (int p = 0; p < 257; p++) begin
            feed(1, 32'h1000 + 32'(p), 1'b1);
            recv_pkt("wrap", 1, 32'h1000 + 32'(p));
        end
        chk("wrap_seq_model", exp_seq, 32'd1);

        // Reset during the second payload word
        feed(3, 32'h300, 1'b1);
        recv_word("mr_hdr", {8'hA5, 8'(exp_seq), 16'd3}, 1'b0);
        recv_word("mr_p0", 32'h300, 1'b0);
        chk("mr_p1_shown", rx_tdata, 32'h301);
        rst_n = 1'b0;
        #1;
        chk("mr_tvalid", {31'd0, rx_tvalid}, 32'd0);
        chk("mr_tdata", rx_tdata, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_in_tready", {31'd0, in_tready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_seq = 0;
        feed(1, 32'h400, 1'b1);
        recv_pkt("mr_after", 1, 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
